// File: rtl/core_pkg.sv
// Shared definitions for the 3-bit-opcode single-issue core.
// Opcode encodings, opcode field width and fetch FSM states.
package core_pkg;

    localparam int OPC_W = 3;

    localparam logic [OPC_W-1:0] OPC_ADD = 3'b000;
    localparam logic [OPC_W-1:0] OPC_SW  = 3'b101;
    localparam logic [OPC_W-1:0] OPC_LW  = 3'b110;
    localparam logic [OPC_W-1:0] OPC_SLL = 3'b111;

    typedef enum logic {
        IDLE,
        RUN
    } fetch_state_e;

    // Every encoding not claimed above decodes as ADDI.
    function automatic logic is_addi(input logic [OPC_W-1:0] opc);
        return !(opc inside {OPC_ADD, OPC_SW, OPC_LW, OPC_SLL});
    endfunction

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bus: instruction memory port plus decode handshake.
// master = fetch stage, slave = memory/decode side.
interface instr_fetch_stage_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic               imem_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               if_valid;
    logic               if_ready;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc;
    logic [2:0]         if_opco;

    modport master (
        output imem_en, imem_addr,
        input  imem_rdata,
        output if_valid, if_instr, if_pc, if_opco,
        input  if_ready
    );

    modport slave (
        input  imem_en, imem_addr,
        output imem_rdata,
        input  if_valid, if_instr, if_pc, if_opco,
        output if_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {instr, pc} with a registered head entry.
// Flush empties it; push and pop may happen in the same cycle.
module fetch_queue #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic [ADDR_W-1:0]  push_pc,
    output logic [1:0]         count,
    output logic [INSTR_W-1:0] head_instr,
    output logic [ADDR_W-1:0]  head_pc
);
    localparam int EW = INSTR_W + ADDR_W;

    logic [EW-1:0] e0_q, e0_d;
    logic [EW-1:0] e1_q, e1_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [EW-1:0] din;

    assign din = {push_instr, push_pc};

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) e0_d = din;
                    else               e1_d = din;
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_d  = e1_q;
                    cnt_d = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        e0_d = din;
                    end else begin
                        e0_d = e1_q;
                        e1_d = din;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign count      = cnt_q;
    assign head_instr = e0_q[EW-1 -: INSTR_W];
    assign head_pc    = e0_q[ADDR_W-1:0];

    a_no_push_full: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(push && !pop && cnt_q == 2'd2)
    );

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch: owns the PC, drives a synchronous-read imem and
// feeds decode from a 2-entry queue through a valid/ready handshake.
module instr_fetch_stage
    import core_pkg::*;
#(
    parameter int               ADDR_W   = 8,
    parameter int               INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    instr_fetch_stage_if.master bus
);
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              infl_q, infl_d;

    logic [1:0]         q_count;
    logic [INSTR_W-1:0] head_instr;
    logic [ADDR_W-1:0]  head_pc;
    logic               pop;
    logic               push;
    logic               issue;
    logic [2:0]         occ_left;

    assign pop = bus.if_valid & bus.if_ready;

    // Words still owed to decode after this cycle's pop.
    assign occ_left = {1'b0, q_count} + {2'b00, infl_q}
                    - {2'b00, pop};

    assign issue = (state_q == RUN) & run_en
                 & ~redirect_valid & (occ_left < 3'd2);

    assign push = infl_q & ~redirect_valid;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tag_d   = tag_q;
        infl_d  = issue;
        unique case (state_q)
            IDLE: state_d = RUN;
            RUN:  state_d = RUN;
        endcase
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d  = pc_q + ADDR_W'(1);
            tag_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            tag_q   <= '0;
            infl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tag_q   <= tag_d;
            infl_q  <= infl_d;
        end
    end

    fetch_queue #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_valid),
        .push_instr (bus.imem_rdata),
        .push_pc    (tag_q),
        .count      (q_count),
        .head_instr (head_instr),
        .head_pc    (head_pc)
    );

    assign bus.imem_en   = issue;
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = (q_count != 2'd0);
    assign bus.if_instr  = head_instr;
    assign bus.if_pc     = head_pc;
    assign bus.if_opco   = head_instr[INSTR_W-1 -: OPC_W];

endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Instruction-fetch front end of the 3-bit-opcode single-issue core. It owns the program counter and drives a synchronous-read instruction memory. It buffers returned words in a 2-entry queue and presents one instruction per cycle, with a valid/ready handshake, to the decode stage. The decode stage hands `if_opco` directly to the control unit.

## Interface
Parameters:
- `ADDR_W`, 8: instruction address width (word addressed).
- `INSTR_W`, 16: instruction width; opcode is `[INSTR_W-1 -: 3]`.
- `RESET_PC`, 0: PC value after reset.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run_en`  in  1  permits new fetches; does not affect draining.
- `redirect_valid`  in  1  replace PC, flush the queue and discard any in-flight fetch.
- `redirect_pc`  in  ADDR_W  new PC, sampled when `redirect_valid`=1.
- `imem_en`  out  1  fetch request this cycle.
- `imem_addr`  out  ADDR_W  fetch address; equals the PC register.
- `imem_rdata`  in  INSTR_W  memory data, valid exactly 1 cycle after `imem_en`.
- `if_valid`  out  1  head of queue is valid.
- `if_ready`  in  1  decode accepts the head this cycle.
- `if_instr`  out  INSTR_W  head instruction.
- `if_pc`  out  ADDR_W  address of the head instruction.
- `if_opco`  out  3  `if_instr[INSTR_W-1 -: 3]`; feeds the control unit.

## Operation
- State machine:
  - IDLE: entered from reset; leaves to RUN on the first clock edge after `rst_n` rises.
  - RUN: normal operation.
  - No other states.
- Occupancy: `occ = q_count + inflight`, where `q_count` is 0..2 and `inflight` is 0..1. `pop = if_valid & if_ready`.
- Issue condition, evaluated combinationally: `imem_en = (state==RUN) & run_en & ~redirect_valid & (occ - pop < 2)`.
- On issue:
  - `inflight` ← 1.
  - `tag_pc` ← PC.
  - PC ← PC+1, modulo 2^ADDR_W, so it wraps from all-ones to 0.
- Response cycle (`inflight`=1, no redirect): push `{imem_rdata, tag_pc}` into the queue.
  - This may coincide with a pop; the queue is then a simultaneous push/pop and count is unchanged.
- Queue:
  - FIFO order.
  - Head is registered; `if_instr`/`if_pc` stay stable while `if_valid & ~if_ready`.
  - The occupancy rule guarantees there is never a push to a full queue; an assertion checks this.
- Redirect (has priority over everything in the same cycle):
  - PC ← `redirect_pc`.
  - `q_count` ← 0, so `if_valid` drops on the next cycle.
  - `inflight` ← 0; the response arriving next cycle is ignored.
  - A pop in the redirect cycle still completes (decode sees the handshake).
  - No fetch is issued in the redirect cycle.
- `run_en`=0: no issue. In-flight and queued words still deliver. PC is held.
- Reset values (asynchronous, immediate on `rst_n`=0):
  - state=IDLE, PC=`RESET_PC`, `q_count`=0, `inflight`=0.
  - `if_valid`=0, `if_instr`=0, `if_pc`=0, `imem_en`=0.
  - A response pending at reset is lost.

## Timing
- Fetch latency: issue at cycle t → queue push at end of t+1 → `if_valid` at t+2.
- After reset release:
  - Cycle 0: IDLE.
  - Cycle 1: first `imem_en` with address `RESET_PC`.
  - Cycle 3: first `if_valid`.
- Steady state with `if_ready`=1: one instruction per cycle, no bubbles.
- Redirect at cycle t:
  - Fetch of `redirect_pc` issued at t+1.
  - `if_valid`=0 during t+1..t+2.
  - Redirect target valid at t+3.
- Back-pressure: at most 2 words held (1 queued + 1 in flight, or 2 queued). Fetch resumes in the cycle `occ - pop` drops below 2.

## Structure
- Shared package `core_pkg`:
  - Opcode constants: ADD=000, ADDI=default, SW=101, LW=110, SLL=111.
  - Opcode field position.
  - Fetch state enum `{IDLE, RUN}`.
- Sub-module `fetch_queue`:
  - 2-entry synchronous FIFO of `{INSTR_W, ADDR_W}`.
  - Ports: push, pop, flush, count, head data.
  - Asynchronous active-low reset.

## Test plan
- Reset release, `run_en`=1, `if_ready`=1, ROM[a]=a·0x0101:
  - `imem_addr` 0,1,2… on consecutive cycles from cycle 1.
  - `if_valid` from cycle 3.
  - `if_pc` 0,1,2…; `if_instr` 0x0000,0x0101,0x0202….
- Back-pressure, `if_ready`=0 for cycles 5–9:
  - `if_instr` held constant.
  - `imem_en`=0 once `occ`=2.
  - After release, the `if_pc` sequence continues with no gap or duplicate.
- Redirect to 0x40 while a fetch is in flight:
  - In-flight word is never presented.
  - `if_valid` is low for exactly 2 cycles.
  - Next `if_pc`=0x40.
- Wrap: redirect to 0xFE → `if_pc` 0xFE, 0xFF, 0x00.
- `rst_n` pulsed low mid-stream: `if_valid`/`imem_en` go 0 without a clock edge; restart fetches from `RESET_PC` with cycle-3 latency.
- `run_en` dropped with 2 words outstanding: both delivered in order, then `if_valid`=0 and PC held. Re-enabling resumes at the held PC.
